fwd_pipe_tracker: RTL

- Producer side of the decode-stage forwarding and flag interface.
- Registers the decoded destination and write-control fields of each instruction through two pipeline slots. "_Reg" is one cycle behind decode (EX). "_Ex" is two cycles behind decode (MEM).
- Drives those slots back to the decoder's forwarding comparators.
- Owns the architectural NZVC flag register, detects load-use hazards (stall), inserts bubbles on stall/flush, and keeps a saturating stall counter.

---
 rtl/fwd_pipe_tracker.sv | 104 ++++++++++
 1 files changed

// File: rtl/fwd_pipe_tracker.sv
// Decode-side forwarding producer: tracks destination/write fields through the EX (_Reg) and
// MEM (_Ex) slots, owns the NZVC flags, and detects load-use hazards with a stall counter.
module fwd_pipe_tracker #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rd_Dec,
  input  logic             RegWrite_Dec,
  input  logic [1:0]       RegWrSrc_Dec,
  input  logic             SetFlag_Dec,
  input  logic             MemRead_Dec,
  input  logic [REG_W-1:0] RegReadA,
  input  logic [REG_W-1:0] RegReadB,
  input  logic             flush,
  input  logic             NewZero,
  input  logic             NewNegative,
  input  logic             NewOverflow,
  input  logic             NewCarryout,
  output logic [REG_W-1:0] Rd_Reg,
  output logic             RegWrite_Reg,
  output logic [1:0]       RegWrSrc_Reg,
  output logic             SetFlag_Reg,
  output logic             MemRead_Reg,
  output logic [REG_W-1:0] Rd_Ex,
  output logic             RegWrite_Ex,
  output logic [1:0]       RegWrSrc_Ex,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             carryout,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [REG_W-1:0] ZeroIdx = REG_W'(ZERO_REG);

  logic [REG_W-1:0] rd_reg_d;
  logic             reg_write_reg_d;
  logic [1:0]       reg_wr_src_reg_d;
  logic             set_flag_reg_d;
  logic             mem_read_reg_d;

  // Load in EX whose result a decode source needs; flush kills the consumer so no hazard.
  always_comb begin
    stall = MemRead_Reg & RegWrite_Reg & (Rd_Reg != ZeroIdx) &
            ((RegReadA == Rd_Reg) | (RegReadB == Rd_Reg)) & ~flush;
  end

  always_comb begin
    rd_reg_d         = Rd_Dec;
    reg_write_reg_d  = RegWrite_Dec;
    reg_wr_src_reg_d = RegWrSrc_Dec;
    set_flag_reg_d   = SetFlag_Dec;
    mem_read_reg_d   = MemRead_Dec;
    if (flush || stall) begin
      rd_reg_d         = ZeroIdx;
      reg_write_reg_d  = 1'b0;
      reg_wr_src_reg_d = 2'b00;
      set_flag_reg_d   = 1'b0;
      mem_read_reg_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Rd_Reg       <= ZeroIdx;
      RegWrite_Reg <= 1'b0;
      RegWrSrc_Reg <= 2'b00;
      SetFlag_Reg  <= 1'b0;
      MemRead_Reg  <= 1'b0;
      Rd_Ex        <= ZeroIdx;
      RegWrite_Ex  <= 1'b0;
      RegWrSrc_Ex  <= 2'b00;
      zero         <= 1'b0;
      negative     <= 1'b0;
      overflow     <= 1'b0;
      carryout     <= 1'b0;
      stall_count  <= '0;
    end else begin
      Rd_Reg       <= rd_reg_d;
      RegWrite_Reg <= reg_write_reg_d;
      RegWrSrc_Reg <= reg_wr_src_reg_d;
      SetFlag_Reg  <= set_flag_reg_d;
      MemRead_Reg  <= mem_read_reg_d;
      // MEM slot is never held: a stalled load still advances.
      Rd_Ex        <= Rd_Reg;
      RegWrite_Ex  <= RegWrite_Reg;
      RegWrSrc_Ex  <= RegWrSrc_Reg;
      if (SetFlag_Reg) begin
        zero     <= NewZero;
        negative <= NewNegative;
        overflow <= NewOverflow;
        carryout <= NewCarryout;
      end
      if (stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule
